// File: rtl/game_sequencer.sv
// Game-flow sequencer: broadcasts row commands, paces gravity, selects pieces, clears full rows, keeps score.
// Optional: define SEQ_LEVEL_SPEEDUP_EN to shorten the drop interval as the score climbs.
module game_sequencer #(
   parameter int ROWS       = 20,
   parameter int DROP_TICKS = 25000000,
   parameter int CNT_W      = 25,
   parameter int ROW_W      = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             fast_drop,
   input  logic             stop_any,
   input  logic             endgame_any,
   input  logic [ROWS-1:0]  full_rows,
   output logic [1:0]       state,
   output logic [2:0]       spawn_sel,
   output logic [ROW_W-1:0] shift_row,
   output logic             game_over,
   output logic [15:0]      score
);

   typedef enum logic [1:0] {
      CMD_CHECK = 2'b00,
      CMD_MOVE  = 2'b01,
      CMD_WRSEL = 2'b10,
      CMD_SHIFT = 2'b11
   } cmd_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SPAWN,
      S_SPAWN_CHK,
      S_WAIT,
      S_MOVE,
      S_MOVE_CHK,
      S_CLR_SCAN,
      S_CLR_SHIFT,
      S_OVER
   } fsm_t;

   localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(DROP_TICKS);
   localparam logic [CNT_W-1:0] LP_STEP = CNT_W'(DROP_TICKS >> 3);

   fsm_t             r_fsm;
   cmd_t             r_cmd;
   logic [2:0]       r_lfsr;
   logic [2:0]       r_spawn_sel;
   logic [ROW_W-1:0] r_shift_row;
   logic             r_game_over;
   logic [15:0]      r_score;
   logic [CNT_W-1:0] r_timer;

   logic [2:0]       w_lfsr_next;
   logic [2:0]       w_piece;
   logic [ROW_W-1:0] w_low;
   logic [CNT_W-1:0] w_base;
   logic [CNT_W-1:0] w_interval;
   logic [CNT_W-1:0] w_limit;

   // x^3+x^2+1; the all-ones state is folded onto piece 0
   assign w_lfsr_next = {r_lfsr[1:0], r_lfsr[2] ^ r_lfsr[1]};
   assign w_piece     = (r_lfsr == 3'd7) ? 3'd0 : r_lfsr;

   always_comb begin
      w_low = '0;
      for (int unsigned i = ROWS; i > 0; i--) begin
         if (full_rows[i-1]) w_low = ROW_W'(i - 1);
      end
   end

`ifdef SEQ_LEVEL_SPEEDUP_EN
   logic [2:0] w_level;
   always_comb begin
      w_level = (r_score[15:3] > 13'd7) ? 3'd7 : r_score[5:3];
      w_base  = LP_FULL - CNT_W'(w_level) * LP_STEP;
   end
`else
   assign w_base = LP_FULL;
`endif

   assign w_interval = fast_drop ? (w_base >> 3) : w_base;
   assign w_limit    = w_interval - CNT_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fsm       <= S_IDLE;
         r_cmd       <= CMD_CHECK;
         r_lfsr      <= 3'b001;
         r_spawn_sel <= '0;
         r_shift_row <= '0;
         r_game_over <= 1'b0;
         r_score     <= '0;
         r_timer     <= '0;
      end else begin
         case (r_fsm)
            S_IDLE: begin
               if (start) begin
                  r_fsm       <= S_SPAWN;
                  r_cmd       <= CMD_WRSEL;
                  r_spawn_sel <= w_piece;
                  r_score     <= '0;
               end
            end
            S_SPAWN: begin
               r_fsm <= S_SPAWN_CHK;
               r_cmd <= CMD_CHECK;
            end
            S_SPAWN_CHK: begin
               if (endgame_any) begin
                  r_fsm       <= S_OVER;
                  r_game_over <= 1'b1;
               end else begin
                  r_lfsr <= w_lfsr_next;
                  r_fsm  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_timer >= w_limit) begin
                  r_timer <= '0;
                  r_fsm   <= S_MOVE;
                  r_cmd   <= CMD_MOVE;
               end else begin
                  r_timer <= r_timer + CNT_W'(1);
               end
            end
            S_MOVE: begin
               r_fsm <= S_MOVE_CHK;
               r_cmd <= CMD_CHECK;
            end
            S_MOVE_CHK: begin
               r_fsm <= stop_any ? S_CLR_SCAN : S_WAIT;
            end
            // each cleared row costs one SCAN/SHIFT pair; rows update full_rows during SHIFT
            S_CLR_SCAN: begin
               if (full_rows == '0) begin
                  r_fsm       <= S_SPAWN;
                  r_cmd       <= CMD_WRSEL;
                  r_spawn_sel <= w_piece;
               end else begin
                  r_shift_row <= w_low;
                  if (r_score != 16'hFFFF) r_score <= r_score + 16'd1;
                  r_fsm       <= S_CLR_SHIFT;
                  r_cmd       <= CMD_SHIFT;
               end
            end
            S_CLR_SHIFT: begin
               r_fsm <= S_CLR_SCAN;
               r_cmd <= CMD_CHECK;
            end
            S_OVER: begin
               r_fsm <= S_OVER;
            end
            default: begin
               r_fsm <= S_IDLE;
               r_cmd <= CMD_CHECK;
            end
         endcase
      end
   end

   assign state     = r_cmd;
   assign spawn_sel = r_spawn_sel;
   assign shift_row = r_shift_row;
   assign game_over = r_game_over;
   assign score     = r_score;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with DROP_TICKS=16; stimulus and checks on the falling edge.
module tb_game_sequencer;

   localparam int ROWS = 20;
   localparam int DT   = 16;
   localparam int CW   = 8;
   localparam int RW   = 5;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic            fast_drop = 1'b0;
   logic            stop_any = 1'b0;
   logic            endgame_any = 1'b0;
   logic [ROWS-1:0] full_rows = '0;
   logic [1:0]      state;
   logic [2:0]      spawn_sel;
   logic [RW-1:0]   shift_row;
   logic            game_over;
   logic [15:0]     score;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   game_sequencer #(
      .ROWS(ROWS),
      .DROP_TICKS(DT),
      .CNT_W(CW),
      .ROW_W(RW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .fast_drop(fast_drop),
      .stop_any(stop_any),
      .endgame_any(endgame_any),
      .full_rows(full_rows),
      .state(state),
      .spawn_sel(spawn_sel),
      .shift_row(shift_row),
      .game_over(game_over),
      .score(score)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      cyc(2);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_spawn_sel", 32'(spawn_sel), 32'd0);
      chk("rst_shift_row", 32'(shift_row), 32'd0);
      chk("rst_game_over", 32'(game_over), 32'd0);
      chk("rst_score", 32'(score), 32'd0);
      reset = 1'b0;
      cyc(1);
      chk("idle_state", 32'(state), 32'd0);

      // first piece: SPAWN, SPAWN_CHK, 16 WAIT, MOVE, MOVE_CHK
      start = 1'b1;
      cyc(1);
      chk("spawn1_state", 32'(state), 32'd2);
      chk("spawn1_sel", 32'(spawn_sel), 32'd1);
      start = 1'b0;
      for (int i = 0; i < 17; i++) begin
         cyc(1);
         chk("wait_normal_state", 32'(state), 32'd0);
      end
      cyc(1);
      chk("move1_state", 32'(state), 32'd1);
      cyc(1);
      chk("movechk1_state", 32'(state), 32'd0);

      // fast drop: two WAIT cycles; stop_any raised during WAIT must not divert
      fast_drop = 1'b1;
      cyc(1);
      chk("fast_wait0", 32'(state), 32'd0);
      stop_any = 1'b1;
      cyc(1);
      chk("fast_wait1", 32'(state), 32'd0);
      cyc(1);
      chk("fast_move", 32'(state), 32'd1);
      fast_drop = 1'b0;
      cyc(1);
      chk("movechk2_state", 32'(state), 32'd0);

      // stop with no full rows: CLR_SCAN then straight to SPAWN
      cyc(1);
      chk("clrscan_empty", 32'(state), 32'd0);
      stop_any = 1'b0;
      cyc(1);
      chk("spawn2_state", 32'(state), 32'd2);
      chk("spawn2_sel", 32'(spawn_sel), 32'd2);
      chk("spawn2_score", 32'(score), 32'd0);

      // clear rows 0 and 2
      fast_drop = 1'b1;
      cyc(1);
      chk("spawnchk2", 32'(state), 32'd0);
      cyc(2);
      chk("wait_before_move3", 32'(state), 32'd0);
      cyc(1);
      chk("move3_state", 32'(state), 32'd1);
      stop_any  = 1'b1;
      full_rows = 20'h00005;
      cyc(1);
      chk("movechk3", 32'(state), 32'd0);
      cyc(1);
      chk("clrscan_a", 32'(state), 32'd0);
      stop_any = 1'b0;
      cyc(1);
      chk("shift_a_state", 32'(state), 32'd3);
      chk("shift_a_row", 32'(shift_row), 32'd0);
      chk("shift_a_score", 32'(score), 32'd1);
      full_rows = 20'h00004;
      cyc(1);
      chk("clrscan_b", 32'(state), 32'd0);
      cyc(1);
      chk("shift_b_state", 32'(state), 32'd3);
      chk("shift_b_row", 32'(shift_row), 32'd2);
      chk("shift_b_score", 32'(score), 32'd2);
      full_rows = '0;
      cyc(1);
      chk("clrscan_c", 32'(state), 32'd0);
      cyc(1);
      chk("spawn3_state", 32'(state), 32'd2);
      chk("spawn3_sel", 32'(spawn_sel), 32'd5);
      chk("spawn3_score", 32'(score), 32'd2);

      // endgame during SPAWN_CHK
      fast_drop   = 1'b0;
      endgame_any = 1'b1;
      cyc(1);
      chk("spawnchk3_state", 32'(state), 32'd0);
      chk("spawnchk3_over", 32'(game_over), 32'd0);
      cyc(1);
      chk("over_flag", 32'(game_over), 32'd1);
      endgame_any = 1'b0;
      for (int i = 0; i < 100; i++) begin
         start    = (i % 10 == 0);
         stop_any = (i % 7 == 0);
         cyc(1);
         chk("over_state_held", 32'(state), 32'd0);
         chk("over_flag_held", 32'(game_over), 32'd1);
      end
      start    = 1'b0;
      stop_any = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("over_reset_flag", 32'(game_over), 32'd0);
      chk("over_reset_score", 32'(score), 32'd0);
      cyc(1);
      reset = 1'b0;

      // asynchronous reset in the middle of CLR_SHIFT, top row full
      cyc(1);
      start = 1'b1;
      cyc(1);
      chk("spawn4_state", 32'(state), 32'd2);
      chk("spawn4_sel", 32'(spawn_sel), 32'd1);
      start     = 1'b0;
      fast_drop = 1'b1;
      cyc(3);
      cyc(1);
      chk("move4_state", 32'(state), 32'd1);
      stop_any  = 1'b1;
      full_rows = 20'h80000;
      cyc(2);
      stop_any = 1'b0;
      cyc(1);
      chk("shift4_state", 32'(state), 32'd3);
      chk("shift4_row", 32'(shift_row), 32'd19);
      chk("shift4_score", 32'(score), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_state", 32'(state), 32'd0);
      chk("async_score", 32'(score), 32'd0);
      chk("async_row", 32'(shift_row), 32'd0);
      chk("async_sel", 32'(spawn_sel), 32'd0);
      full_rows = '0;
      fast_drop = 1'b0;
      cyc(1);
      reset = 1'b0;

`ifdef SEQ_LEVEL_SPEEDUP_EN
      // eight clears reach level 1: interval 16-2=14
      cyc(1);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(1);
      fast_drop = 1'b1;
      cyc(2);
      cyc(1);
      chk("lvl_move", 32'(state), 32'd1);
      stop_any  = 1'b1;
      full_rows = 20'h000FF;
      cyc(2);
      stop_any  = 1'b0;
      fast_drop = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cyc(1);
         chk("lvl_shift_state", 32'(state), 32'd3);
         chk("lvl_shift_row", 32'(shift_row), 32'(k));
         full_rows[k] = 1'b0;
         cyc(1);
         chk("lvl_scan_state", 32'(state), 32'd0);
      end
      cyc(1);
      chk("lvl_spawn_state", 32'(state), 32'd2);
      chk("lvl_score", 32'(score), 32'd8);
      for (int i = 0; i < 15; i++) begin
         cyc(1);
         chk("lvl_wait_state", 32'(state), 32'd0);
      end
      cyc(1);
      chk("lvl_move_14", 32'(state), 32'd1);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Central game-flow FSM upstream of the per-row block registers.
- Broadcasts the 2-bit row command: 00 check, 01 move, 10 write select, 11 shift.
- Paces gravity with a drop timer and selects the next piece pattern for the write generator.
- Consumes the rows' OR-reduced Stop/endgame flags and row-full flags; sequences line clears and keeps the score.

Parameters:
- ROWS, 20: playfield height; width of full_rows.
- DROP_TICKS, 25000000: clk cycles between gravity steps at normal speed; must be >= 8.
- CNT_W, 25: drop timer width; must hold DROP_TICKS-1.
- ROW_W, 5: width of shift_row; must satisfy 2^ROW_W >= ROWS.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  level; begins a game when in IDLE
- fast_drop  in  1  level; shortens the drop interval while high
- stop_any  in  1  OR of all row Stop outputs
- endgame_any  in  1  OR of all row endgame outputs
- full_rows  in  ROWS  bit i high when row i is all ones
- state  out  2  command broadcast to all row blocks
- spawn_sel  out  3  piece pattern index 0..6 for the write generator
- shift_row  out  ROW_W  index of the row being cleared; valid when state=11
- game_over  out  1  high in OVER
- score  out  16  total lines cleared, saturating

Behaviour:
- Clocking/reset: one clock domain. Reset is asynchronous, active-high.
- Reset values: FSM=IDLE, state=00, spawn_sel=0, shift_row=0, game_over=0, score=0, drop timer=0, LFSR=3'b001.
- Row handshake: each row registers Stop/endgame one cycle after a command. So every 01 or 10 command lasts exactly one cycle and is followed by one 00 cycle in which the flag is sampled.
- FSM states; state output shown in brackets:
  - IDLE [00]: on start=1, go to SPAWN. score clears to 0 on that edge.
  - SPAWN [10]: one cycle. spawn_sel holds the current LFSR value. Go to SPAWN_CHK.
  - SPAWN_CHK [00]: if endgame_any=1, go to OVER. Otherwise advance the LFSR and go to WAIT.
  - WAIT [00]: drop timer increments each cycle. When timer >= interval-1, clear the timer and go to MOVE. The >= compare means that if fast_drop rises after the timer has already passed the short interval, MOVE fires on the next cycle.
  - MOVE [01]: one cycle. Go to MOVE_CHK.
  - MOVE_CHK [00]: if stop_any=1, go to CLR_SCAN. Otherwise go to WAIT.
  - CLR_SCAN [00]: if full_rows==0, go to SPAWN. Otherwise latch shift_row = lowest set index (priority encoder, bit 0 wins), increment score (hold at 16'hFFFF), go to CLR_SHIFT.
  - CLR_SHIFT [11]: one cycle. Go back to CLR_SCAN, which re-evaluates the updated full_rows. This repeats until no row is full.
  - OVER [00]: game_over=1. Leaves only via reset; start is ignored.
- Drop interval: DROP_TICKS when fast_drop=0; DROP_TICKS>>3 when fast_drop=1. fast_drop is sampled every WAIT cycle.
- Piece select LFSR: 3-bit, taps x^3+x^2+1. A raw value of 7 is mapped to 0, so spawn_sel is always in 0..6. The LFSR advances only in SPAWN_CHK, which makes the piece sequence deterministic from reset.
- Ignored inputs:
  - start outside IDLE.
  - stop_any outside MOVE_CHK.
  - endgame_any outside SPAWN_CHK.
- Simultaneous stop_any and endgame_any: each is acted on only in its own check state, never both.
- Reset asserted mid-clear or mid-move returns all outputs to reset values immediately (asynchronous).

Optional Feature:
- Macro: SEQ_LEVEL_SPEEDUP_EN.
- Defined: level = min(score>>3, 7). Base interval = DROP_TICKS - level*(DROP_TICKS>>3). fast_drop still applies >>3 to this base. The level is recomputed combinationally from score.
- Undefined: base interval is fixed at DROP_TICKS, and no level logic is synthesized.

Test Plan (DROP_TICKS=16):
- Reset then start pulse: state sequence 10, 00, then 00 x16, then 01, 00. spawn_sel=1 on the first SPAWN, and 2 on the second SPAWN (LFSR 001→010).
- fast_drop held from the start of WAIT: MOVE is issued after 2 WAIT cycles instead of 16.
- stop_any=1 in MOVE_CHK with full_rows=0: CLR_SCAN, then SPAWN (state=10) with no 11 issued; score unchanged.
- stop_any=1 with full_rows=20'h00005, and the bench clears each bit after its shift:
  - state=11 with shift_row=0;
  - then state=11 with shift_row=2;
  - then SPAWN; score=2.
- endgame_any=1 during SPAWN_CHK: game_over=1 with state held at 00 for 100 cycles; start pulses ignored; reset clears game_over.
- Reset asserted during CLR_SHIFT: state=00 and score=0 in the same cycle without a clock edge; with SEQ_LEVEL_SPEEDUP_EN, score=8 gives a 14-cycle interval.
